// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared constants, FSM state type and a metric helper for the
// Viterbi decoder ACS scheduling logic.
package viterbi_pkg;

    localparam int NUM_STATES  = 64;
    localparam int NUM_UNITS   = 8;
    localparam int PM_W        = 8;
    localparam int STEP_W      = 16;

    // Butterfly groups per trellis step and the index widths derived from it.
    localparam int G           = NUM_STATES / (2 * NUM_UNITS);
    localparam int BFLY_IDX_W  = $clog2(NUM_STATES / 2);
    localparam int GRP_W       = (G > 1) ? $clog2(G) : 1;

    localparam logic [PM_W-1:0] PM_INIT_MAX = {PM_W{1'b1}};
    localparam logic [PM_W-1:0] NORM_THRESH = PM_W'(128);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WRAP = 2'd2
    } sched_state_e;

    // Smaller of two path metrics.
    function automatic logic [PM_W-1:0] pm_min(input logic [PM_W-1:0] a,
                                               input logic [PM_W-1:0] b);
        logic [PM_W-1:0] res;
        if (a < b) begin
            res = a;
        end else begin
            res = b;
        end
        return res;
    endfunction

endpackage

// File: rtl/pm_min_tracker.sv
// pm_min_tracker: running minimum of the per-group path metrics over one
// trellis step, plus the threshold compare that yields the subtraction value
// for the next step. Only present when ACS_NORM_EN is defined.
`ifdef ACS_NORM_EN
module pm_min_tracker
    import viterbi_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clr,
    input  logic            i_upd,
    input  logic [PM_W-1:0] i_val,
    output logic [PM_W-1:0] o_norm
);

    logic [PM_W-1:0] r_min;

    // Running minimum: restart at all-ones on clear, fold in each group value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_min <= PM_INIT_MAX;
        end else if (i_clr) begin
            r_min <= PM_INIT_MAX;
        end else if (i_upd) begin
            r_min <= pm_min(r_min, i_val);
        end else begin
            r_min <= r_min;
        end
    end

    // Only subtract when every surviving metric is at or above the threshold.
    always_comb begin
        o_norm = '0;
        if (r_min >= NORM_THRESH) begin
            o_norm = r_min;
        end else begin
            o_norm = '0;
        end
    end

endmodule
`endif

// File: rtl/acs_scheduler.sv
// acs_scheduler: sequences the shared butterfly/ACS units of the 64-state
// rate-1/2 Viterbi decoder. One symbol pair per trellis step is accepted, the
// 32 butterflies are walked in groups of NUM_UNITS, the ping-pong path-metric
// banks are swapped at the end of each step and step completion is signalled.
// Optional macro ACS_NORM_EN: enables min tracking and path-metric
// normalization; when undefined norm_sub stays 0 and grp_min is unused.
module acs_scheduler
    import viterbi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [1:0]            rx_pair,
    input  logic                  frame_start,
    output logic                  rx_ready,
    output logic                  grp_valid,
    output logic [BFLY_IDX_W-1:0] bfly_base,
    output logic [1:0]            rx_pair_q,
    output logic                  pm_init,
    output logic                  pm_rd_bank,
    output logic [PM_W-1:0]       norm_sub,
    input  logic [PM_W-1:0]       grp_min,
    output logic                  step_done,
    output logic [STEP_W-1:0]     step_cnt
);

    localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(G - 1);

    sched_state_e          r_state;
    sched_state_e          w_state_nx;
    logic [GRP_W-1:0]      r_grp_cnt;
    logic [GRP_W-1:0]      w_grp_nx;
    logic [BFLY_IDX_W-1:0] w_bfly_nx;
    logic                  w_accept;
    logic                  w_in_run;
    logic                  w_in_wrap;
    logic [PM_W-1:0]       w_norm_nx;

    logic                  r_rx_ready;
    logic                  r_grp_valid;
    logic [BFLY_IDX_W-1:0] r_bfly_base;
    logic [1:0]            r_rx_pair_q;
    logic                  r_pm_init;
    logic                  r_pm_rd_bank;
    logic [PM_W-1:0]       r_norm_sub;
    logic                  r_step_done;
    logic [STEP_W-1:0]     r_step_cnt;

    assign w_in_run  = (r_state == RUN);
    assign w_in_wrap = (r_state == WRAP);

`ifdef ACS_NORM_EN
    pm_min_tracker u_min_tracker (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_clr  (w_in_wrap),
        .i_upd  (w_in_run),
        .i_val  (grp_min),
        .o_norm (w_norm_nx)
    );
`else
    logic w_unused_grp_min;
    assign w_unused_grp_min = ^grp_min;
    assign w_norm_nx        = '0;
`endif

    // Next state, group counter and symbol acceptance.
    always_comb begin
        w_state_nx = r_state;
        w_grp_nx   = r_grp_cnt;
        w_accept   = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_valid && r_rx_ready) begin
                    w_accept   = 1'b1;
                    w_state_nx = RUN;
                    w_grp_nx   = '0;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            RUN: begin
                if (r_grp_cnt == GRP_LAST) begin
                    w_state_nx = WRAP;
                    w_grp_nx   = '0;
                end else begin
                    w_grp_nx   = r_grp_cnt + GRP_W'(1);
                end
            end
            WRAP: begin
                w_grp_nx = '0;
                if (rx_valid && r_rx_ready) begin
                    w_accept   = 1'b1;
                    w_state_nx = RUN;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_grp_nx   = '0;
            end
        endcase
    end

    // First butterfly of the group that will be presented next cycle.
    always_comb begin
        w_bfly_nx = BFLY_IDX_W'(w_grp_nx) * BFLY_IDX_W'(NUM_UNITS);
    end

    // FSM state and registered handshake/sequencing outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grp_cnt   <= '0;
            r_rx_ready  <= 1'b0;
            r_grp_valid <= 1'b0;
            r_bfly_base <= '0;
            r_step_done <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_grp_cnt   <= w_grp_nx;
            r_rx_ready  <= (w_state_nx != RUN);
            r_grp_valid <= (w_state_nx == RUN);
            r_bfly_base <= w_bfly_nx;
            r_step_done <= (w_state_nx == WRAP);
        end
    end

    // Per-step context: latched symbol, init flag, normalization, step count
    // and bank select. Acceptance overrides the end-of-step update so a frame
    // start in WRAP clears the counter and the normalization value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_pair_q  <= 2'b00;
            r_pm_init    <= 1'b0;
            r_norm_sub   <= '0;
            r_step_cnt   <= '0;
            r_pm_rd_bank <= 1'b0;
        end else begin
            if (w_in_wrap) begin
                r_pm_rd_bank <= ~r_pm_rd_bank;
            end else begin
                r_pm_rd_bank <= r_pm_rd_bank;
            end
            if (w_accept) begin
                r_rx_pair_q <= rx_pair;
                r_pm_init   <= frame_start;
                if (frame_start) begin
                    r_step_cnt <= '0;
                    r_norm_sub <= '0;
                end else if (w_in_wrap) begin
                    r_step_cnt <= r_step_cnt + STEP_W'(1);
                    r_norm_sub <= w_norm_nx;
                end else begin
                    r_step_cnt <= r_step_cnt;
                    r_norm_sub <= r_norm_sub;
                end
            end else if (w_in_wrap) begin
                r_pm_init  <= 1'b0;
                r_step_cnt <= r_step_cnt + STEP_W'(1);
                r_norm_sub <= w_norm_nx;
            end else begin
                r_pm_init  <= r_pm_init;
                r_step_cnt <= r_step_cnt;
                r_norm_sub <= r_norm_sub;
            end
        end
    end

    assign rx_ready   = r_rx_ready;
    assign grp_valid  = r_grp_valid;
    assign bfly_base  = r_bfly_base;
    assign rx_pair_q  = r_rx_pair_q;
    assign pm_init    = r_pm_init;
    assign pm_rd_bank = r_pm_rd_bank;
    assign norm_sub   = r_norm_sub;
    assign step_done  = r_step_done;
    assign step_cnt   = r_step_cnt;

endmodule

// File: tb/tb_acs_scheduler.sv
// tb_acs_scheduler: self-checking bench for acs_scheduler. A step-level
// reference model tracks each trellis step as "cycles since acceptance" and
// derives all outputs from that; directed tables and hand sequences add
// targeted checks on top.
module tb_acs_scheduler;
    import viterbi_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  rx_valid;
    logic [1:0]            rx_pair;
    logic                  frame_start;
    logic                  rx_ready;
    logic                  grp_valid;
    logic [BFLY_IDX_W-1:0] bfly_base;
    logic [1:0]            rx_pair_q;
    logic                  pm_init;
    logic                  pm_rd_bank;
    logic [PM_W-1:0]       norm_sub;
    logic [PM_W-1:0]       grp_min;
    logic                  step_done;
    logic [STEP_W-1:0]     step_cnt;

    acs_scheduler dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_pair(rx_pair),
        .frame_start(frame_start), .rx_ready(rx_ready), .grp_valid(grp_valid),
        .bfly_base(bfly_base), .rx_pair_q(rx_pair_q), .pm_init(pm_init),
        .pm_rd_bank(pm_rd_bank), .norm_sub(norm_sub), .grp_min(grp_min),
        .step_done(step_done), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: m_p = 0 idle, 1..4 = group m_p-1 in flight, 5 = wrap.
    int         m_p;
    bit         m_ready;
    logic [1:0] m_pair;
    bit         m_init;
    bit         m_bank;
    int         m_norm;
    int         m_cnt;
    int         m_mins[$];

    typedef struct {
        logic [1:0]      pair;
        logic            fs;
        logic [3:0][7:0] g;
        logic            exp_init;
        int              exp_norm_in;
        int              exp_cnt;
        logic            exp_bank;
        int              exp_norm_out;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int nz(input int v);
`ifdef ACS_NORM_EN
        return v;
`else
        return 0;
`endif
    endfunction

    function automatic int step_norm();
        int mn;
        mn = 255;
        foreach (m_mins[i]) if (m_mins[i] < mn) mn = m_mins[i];
        if (mn >= 128) return nz(mn);
        return 0;
    endfunction

    task automatic model_reset();
        m_p = 0; m_ready = 1'b0; m_pair = 2'b00; m_init = 1'b0;
        m_bank = 1'b0; m_norm = 0; m_cnt = 0; m_mins.delete();
    endtask

    task automatic compare_all();
        bit run;
        run = (m_p >= 1) && (m_p <= G);
        chk("rx_ready", 32'(rx_ready), 32'(m_ready));
        chk("grp_valid", 32'(grp_valid), 32'(run));
        if (run) chk("bfly_base", 32'(bfly_base), 32'((m_p - 1) * 8));
        chk("step_done", 32'(step_done), 32'(m_p == G + 1));
        chk("rx_pair_q", 32'(rx_pair_q), 32'(m_pair));
        chk("pm_init", 32'(pm_init), 32'(m_init));
        chk("pm_rd_bank", 32'(pm_rd_bank), 32'(m_bank));
        chk("norm_sub", 32'(norm_sub), 32'(m_norm));
        chk("step_cnt", 32'(step_cnt), 32'(m_cnt));
    endtask

    // One clock: advance the model with the current inputs, then compare.
    task automatic tick();
        bit acc;
        acc = rx_valid && m_ready;
        if (m_p >= 1 && m_p <= G) m_mins.push_back(int'(grp_min));
        @(posedge clk);
        if (m_p == G + 1) begin
            m_bank = ~m_bank;
            m_cnt  = (m_cnt + 1) & 32'hFFFF;
            m_init = 1'b0;
            m_norm = step_norm();
            m_mins.delete();
        end
        if (acc) begin
            m_pair = rx_pair;
            m_init = frame_start;
            if (frame_start) begin
                m_cnt  = 0;
                m_norm = 0;
            end
            m_p = 1;
            m_mins.delete();
        end else if (m_p == 0 || m_p == G + 1) begin
            m_p = 0;
        end else begin
            m_p++;
        end
        m_ready = !(m_p >= 1 && m_p <= G);
        #1;
        compare_all();
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (rx_ready !== 1'b1 && k < 12) begin
            tick();
            k++;
        end
        if (rx_ready !== 1'b1) chk("ready_timeout", 32'(rx_ready), 32'd1);
    endtask

    task automatic set_vec(input int i, input logic [1:0] pr, input logic fs,
                           input int g0, input int g1, input int g2, input int g3,
                           input logic ei, input int nin, input int cnt,
                           input logic bk, input int nout);
        tbl[i].pair = pr; tbl[i].fs = fs;
        tbl[i].g[0] = 8'(g0); tbl[i].g[1] = 8'(g1);
        tbl[i].g[2] = 8'(g2); tbl[i].g[3] = 8'(g3);
        tbl[i].exp_init = ei; tbl[i].exp_norm_in = nin; tbl[i].exp_cnt = cnt;
        tbl[i].exp_bank = bk; tbl[i].exp_norm_out = nout;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_t[$];
        int bank_seen[$];
        int init_cnt, dones, n_acc, d1, d2;

        rst = 1'b1; rx_valid = 1'b0; rx_pair = 2'b00; frame_start = 1'b0; grp_min = '0;
        model_reset();

        // Reset state.
        @(posedge clk); #1;
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_grp_valid", 32'(grp_valid), 32'd0);
        chk("rst_bfly_base", 32'(bfly_base), 32'd0);
        chk("rst_rx_pair_q", 32'(rx_pair_q), 32'd0);
        chk("rst_pm_init", 32'(pm_init), 32'd0);
        chk("rst_pm_rd_bank", 32'(pm_rd_bank), 32'd0);
        chk("rst_norm_sub", 32'(norm_sub), 32'd0);
        chk("rst_step_done", 32'(step_done), 32'd0);
        chk("rst_step_cnt", 32'(step_cnt), 32'd0);
        @(negedge clk); rst = 1'b0;
        tick();
        chk("rel_rx_ready", 32'(rx_ready), 32'd1);

        // Directed single steps (table).
        set_vec(0, 2'b10, 1'b1, 200, 150, 140, 190, 1'b1, 0,         1, 1'b1, nz(140));
        set_vec(1, 2'b01, 1'b0, 200, 100, 220, 250, 1'b0, nz(140),   2, 1'b0, 0);
        set_vec(2, 2'b11, 1'b0, 128, 255, 130, 129, 1'b0, 0,         3, 1'b1, nz(128));
        set_vec(3, 2'b00, 1'b0, 127, 200, 200, 200, 1'b0, nz(128),   4, 1'b0, 0);
        set_vec(4, 2'b10, 1'b1, 255, 255, 255, 255, 1'b1, 0,         1, 1'b1, nz(255));
        set_vec(5, 2'b01, 1'b0, 250, 240, 230, 129, 1'b0, nz(255),   2, 1'b0, nz(129));
        foreach (tbl[i]) begin
            wait_ready();
            rx_valid = 1'b1; rx_pair = tbl[i].pair; frame_start = tbl[i].fs;
            tick();
            rx_valid = 1'b0; frame_start = 1'b0; rx_pair = 2'b00;
            for (int g = 0; g < G; g++) begin
                grp_min = tbl[i].g[g];
                chk("tbl_grp_valid", 32'(grp_valid), 32'd1);
                chk("tbl_bfly_base", 32'(bfly_base), 32'(g * 8));
                chk("tbl_rx_pair_q", 32'(rx_pair_q), 32'(tbl[i].pair));
                chk("tbl_pm_init", 32'(pm_init), 32'(tbl[i].exp_init));
                chk("tbl_norm_in", 32'(norm_sub), 32'(tbl[i].exp_norm_in));
                tick();
            end
            grp_min = '0;
            chk("tbl_step_done", 32'(step_done), 32'd1);
            tick();
            chk("tbl_step_cnt", 32'(step_cnt), 32'(tbl[i].exp_cnt));
            chk("tbl_bank", 32'(pm_rd_bank), 32'(tbl[i].exp_bank));
            chk("tbl_norm_out", 32'(norm_sub), 32'(tbl[i].exp_norm_out));
        end

        // Back-to-back: three symbols with rx_valid held high.
        wait_ready();
        init_cnt = 0; dones = 0;
        rx_valid = 1'b1; frame_start = 1'b1; rx_pair = 2'b01; grp_min = 8'd200;
        for (int k = 0; k < 40 && dones < 3; k++) begin
            if (rx_valid && rx_ready) acc_t.push_back(k);
            tick();
            if (acc_t.size() >= 1) frame_start = 1'b0;
            if (acc_t.size() >= 3) rx_valid = 1'b0;
            if (grp_valid && bfly_base == 0) bank_seen.push_back(int'(pm_rd_bank));
            if (grp_valid && pm_init) init_cnt++;
            if (step_done) dones++;
        end
        rx_valid = 1'b0;
        chk("b2b_accepts", 32'(acc_t.size()), 32'd3);
        d1 = (acc_t.size() >= 2) ? acc_t[1] - acc_t[0] : -1;
        d2 = (acc_t.size() >= 3) ? acc_t[2] - acc_t[1] : -1;
        chk("b2b_interval1", 32'(d1), 32'd5);
        chk("b2b_interval2", 32'(d2), 32'd5);
        chk("b2b_banks", 32'(bank_seen.size() == 3 && bank_seen[0] == 0 &&
                              bank_seen[1] == 1 && bank_seen[2] == 0), 32'd1);
        chk("b2b_init_cycles", 32'(init_cnt), 32'd4);
        tick();
        chk("b2b_step_cnt", 32'(step_cnt), 32'd3);
        chk("b2b_bank_end", 32'(pm_rd_bank), 32'd1);

        // Asynchronous reset in the third RUN cycle.
        wait_ready();
        rx_valid = 1'b1; frame_start = 1'b0; rx_pair = 2'b11;
        tick();
        rx_valid = 1'b0;
        tick();
        tick();
        chk("pre_rst_grp_valid", 32'(grp_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_grp_valid", 32'(grp_valid), 32'd0);
        chk("arst_step_cnt", 32'(step_cnt), 32'd0);
        chk("arst_rx_ready", 32'(rx_ready), 32'd0);
        chk("arst_pm_rd_bank", 32'(pm_rd_bank), 32'd0);
        model_reset();
        @(negedge clk); rst = 1'b0;
        tick();
        chk("arst_rel_ready", 32'(rx_ready), 32'd1);

        // Frame start accepted in WRAP after five steps.
        n_acc = 0;
        rx_valid = 1'b1; frame_start = 1'b0; rx_pair = 2'b10; grp_min = 8'd200;
        for (int k = 0; k < 60 && n_acc < 6; k++) begin
            if (rx_ready && n_acc == 5) begin
                frame_start = 1'b1;
                chk("fs_in_wrap", 32'(step_done), 32'd1);
            end
            if (rx_valid && rx_ready) n_acc++;
            tick();
        end
        rx_valid = 1'b0; frame_start = 1'b0;
        chk("fs_accepts", 32'(n_acc), 32'd6);
        chk("fs_norm_sub", 32'(norm_sub), 32'd0);
        chk("fs_pm_init", 32'(pm_init), 32'd1);
        dones = 0;
        for (int k = 0; k < 10 && dones == 0; k++) begin
            tick();
            if (step_done) dones++;
        end
        chk("fs_done_seen", 32'(dones), 32'd1);
        tick();
        chk("fs_step_cnt", 32'(step_cnt), 32'd1);

        // Randomized traffic against the model.
        for (int k = 0; k < 800; k++) begin
            rx_valid    = ($urandom_range(0, 3) != 0);
            frame_start = ($urandom_range(0, 15) == 0);
            rx_pair     = 2'($urandom_range(0, 3));
            grp_min     = 8'($urandom_range(100, 255));
            tick();
        end
        rx_valid = 1'b0; frame_start = 1'b0;
        for (int k = 0; k < 6; k++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
